// File: rtl/parking_pkg.sv
// Shared hour constants, car class encoding and the general-pool capacity schedule.
// The schedule is a pure function so the top can evaluate it for both the current and the next hour.
package parking_pkg;

  localparam int HOUR_W        = 5;
  localparam int HOURS_PER_DAY = 24;

  typedef enum logic {
    CLASS_GEN = 1'b0,
    CLASS_UNI = 1'b1
  } car_class_e;

  function automatic int gen_cap_at(
    input logic [HOUR_W-1:0] hour,
    input int                ramp_hour,
    input int                full_hour,
    input int                cap_day,
    input int                step,
    input int                cap_night
  );
    int h;
    int cap;
    h = int'(hour);
    if (h < ramp_hour) begin
      cap = cap_day;
    end else if (h < full_hour) begin
      cap = cap_day + (h - ramp_hour + 1) * step;
      if (cap > cap_night) cap = cap_night;
    end else begin
      cap = cap_night;
    end
    return cap;
  endfunction

endpackage

// File: rtl/parking_hour_clock.sv
// Prescaler and hour-of-day counter; the tick is combinational on the terminal prescaler count.
// The next-hour value is exported so the top can register capacity-dependent outputs in step with the hour.
module parking_hour_clock
  import parking_pkg::*;
#(
  parameter int TICKS_PER_HOUR = 1000,
  parameter int START_HOUR     = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [HOUR_W-1:0] o_hour,
  output logic [HOUR_W-1:0] o_hour_nxt,
  output logic              o_hour_tick
);

  localparam int            PW   = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_HOUR - 1);

  logic [PW-1:0]     r_presc;
  logic [HOUR_W-1:0] r_hour;

  always_comb begin
    o_hour_tick = (r_presc == TERM);
    o_hour_nxt  = r_hour;
    if (o_hour_tick) begin
      o_hour_nxt = (r_hour == HOUR_W'(HOURS_PER_DAY - 1)) ? '0 : r_hour + HOUR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_hour  <= HOUR_W'(START_HOUR);
    end else begin
      r_presc <= o_hour_tick ? '0 : r_presc + PW'(1);
      r_hour  <= o_hour_nxt;
    end
  end

  assign o_hour = r_hour;

endmodule

// File: rtl/parking_zone_ctrl.sv
// Two-pool parking admission controller, one-cycle registered response; every entry gets exactly one ack or rej, no stalls.
// PARKING_SPILL_EN lets general cars refused by a full general pool borrow free university spaces.
module parking_zone_ctrl
  import parking_pkg::*;
#(
  parameter int CNT_W          = 10,
  parameter int UNI_CAP        = 500,
  parameter int GEN_CAP_DAY    = 200,
  parameter int GEN_STEP       = 50,
  parameter int GEN_CAP_NIGHT  = 500,
  parameter int RAMP_HOUR      = 13,
  parameter int FULL_HOUR      = 16,
  parameter int START_HOUR     = 8,
  parameter int TICKS_PER_HOUR = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             car_entered,
  input  logic             is_uni_car_entered,
  input  logic             car_exited,
  input  logic             is_uni_car_exited,
  output logic             entry_ack,
  output logic             entry_rej,
  output logic             exit_err,
  output logic [CNT_W-1:0] uni_parked_car,
  output logic [CNT_W-1:0] parked_car,
  output logic [CNT_W-1:0] uni_vacated_space,
  output logic [CNT_W-1:0] vacated_space,
  output logic             uni_is_vacated_space,
  output logic             is_vacated_space,
  output logic [4:0]       hour
);

  if (UNI_CAP >= (1 << CNT_W) || GEN_CAP_DAY >= (1 << CNT_W) || GEN_CAP_NIGHT >= (1 << CNT_W)) begin : g_cap_check
    $error("parking_zone_ctrl: capacity parameters do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] UNI_CAP_C = CNT_W'(UNI_CAP);
  localparam logic [CNT_W-1:0] RST_GEN_SPACE =
    CNT_W'(gen_cap_at(HOUR_W'(START_HOUR), RAMP_HOUR, FULL_HOUR, GEN_CAP_DAY, GEN_STEP, GEN_CAP_NIGHT));

  logic [HOUR_W-1:0] w_hour;
  logic [HOUR_W-1:0] w_hour_nxt;
  logic              w_hour_tick;

  parking_hour_clock #(
    .TICKS_PER_HOUR (TICKS_PER_HOUR),
    .START_HOUR     (START_HOUR)
  ) u_hour_clock (
    .clk         (clk),
    .rst         (rst),
    .o_hour      (w_hour),
    .o_hour_nxt  (w_hour_nxt),
    .o_hour_tick (w_hour_tick)
  );

  logic [CNT_W-1:0] r_uni_cnt, r_gen_cnt, r_uni_space, r_gen_space;
  logic             r_uni_flag, r_gen_flag, r_ack, r_rej, r_err;
  logic [CNT_W-1:0] w_spill, w_spill_nxt, w_uni_nxt, w_gen_nxt;
  logic [CNT_W-1:0] w_gen_cap, w_gen_cap_nxt, w_uni_space_nxt, w_gen_space_nxt;
  logic             w_uni_ent, w_gen_ent, w_uni_ext, w_gen_ext, w_uni_free, w_gen_free;
  logic             w_uni_ext_ok, w_gen_ext_ok, w_uni_acc, w_gen_main, w_gen_spill;
  logic             w_ack, w_rej, w_err;
  car_class_e       w_ent_class;

  assign w_gen_cap     = CNT_W'(gen_cap_at(w_hour, RAMP_HOUR, FULL_HOUR, GEN_CAP_DAY, GEN_STEP, GEN_CAP_NIGHT));
  assign w_gen_cap_nxt = w_hour_tick ?
    CNT_W'(gen_cap_at(w_hour_nxt, RAMP_HOUR, FULL_HOUR, GEN_CAP_DAY, GEN_STEP, GEN_CAP_NIGHT)) : w_gen_cap;

`ifdef PARKING_SPILL_EN
  logic [CNT_W-1:0] r_spill;
  always_ff @(posedge clk) begin
    if (rst) r_spill <= '0;
    else     r_spill <= w_spill_nxt;
  end
  assign w_spill     = r_spill;
  assign w_gen_spill = w_gen_ent & ~w_gen_main & w_uni_free;
`else
  assign w_spill     = '0;
  assign w_gen_spill = 1'b0;
`endif

  // Admission looks only at registered counts: an exit frees space only for its own pool.
  always_comb begin
    w_ent_class  = car_class_e'(is_uni_car_entered);
    w_uni_ent    = car_entered & (w_ent_class == CLASS_UNI);
    w_gen_ent    = car_entered & (w_ent_class == CLASS_GEN);
    w_uni_ext    = car_exited & is_uni_car_exited;
    w_gen_ext    = car_exited & ~is_uni_car_exited;
    w_uni_free   = (r_uni_cnt + w_spill) < UNI_CAP_C;
    w_gen_free   = r_gen_cnt < w_gen_cap;
    w_uni_ext_ok = w_uni_ext & (r_uni_cnt != '0);
    w_gen_ext_ok = w_gen_ext & ((r_gen_cnt != '0) | (w_spill != '0));
    w_uni_acc    = w_uni_ent & (w_uni_free | w_uni_ext_ok);
    w_gen_main   = w_gen_ent & (w_gen_free | w_gen_ext_ok);
    w_ack        = w_uni_acc | w_gen_main | w_gen_spill;
    w_rej        = car_entered & ~w_ack;
    w_err        = car_exited & ~(w_uni_ext_ok | w_gen_ext_ok);
  end

  always_comb begin
    w_uni_nxt   = r_uni_cnt;
    w_gen_nxt   = r_gen_cnt;
    w_spill_nxt = w_spill;
    if (w_uni_acc && !w_uni_ext_ok)      w_uni_nxt = r_uni_cnt + ONE;
    else if (w_uni_ext_ok && !w_uni_acc) w_uni_nxt = r_uni_cnt - ONE;
    // A general exit returns borrowed university spaces before touching the general count.
    if (w_gen_ext_ok && !w_gen_ent) begin
      if (w_spill != '0) w_spill_nxt = w_spill - ONE;
      else               w_gen_nxt   = r_gen_cnt - ONE;
    end else if (w_gen_main && !w_gen_ext_ok) begin
      w_gen_nxt = r_gen_cnt + ONE;
    end else if (w_gen_spill) begin
      w_spill_nxt = w_spill + ONE;
    end
    w_uni_space_nxt = UNI_CAP_C - w_uni_nxt - w_spill_nxt;
    w_gen_space_nxt = (w_gen_cap_nxt > w_gen_nxt) ? (w_gen_cap_nxt - w_gen_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_uni_cnt   <= '0;
      r_gen_cnt   <= '0;
      r_uni_space <= UNI_CAP_C;
      r_gen_space <= RST_GEN_SPACE;
      r_uni_flag  <= (UNI_CAP_C != '0);
      r_gen_flag  <= (RST_GEN_SPACE != '0);
      r_ack       <= 1'b0;
      r_rej       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_uni_cnt   <= w_uni_nxt;
      r_gen_cnt   <= w_gen_nxt;
      r_uni_space <= w_uni_space_nxt;
      r_gen_space <= w_gen_space_nxt;
      r_uni_flag  <= (w_uni_space_nxt != '0);
      r_gen_flag  <= (w_gen_space_nxt != '0);
      r_ack       <= w_ack;
      r_rej       <= w_rej;
      r_err       <= w_err;
    end
  end

  assign entry_ack            = r_ack;
  assign entry_rej            = r_rej;
  assign exit_err             = r_err;
  assign uni_parked_car       = r_uni_cnt;
  assign parked_car           = r_gen_cnt;
  assign uni_vacated_space    = r_uni_space;
  assign vacated_space        = r_gen_space;
  assign uni_is_vacated_space = r_uni_flag;
  assign is_vacated_space     = r_gen_flag;
  assign hour                 = w_hour;

endmodule

// File: tb/tb_parking_zone_ctrl.sv
// Bench for parking_zone_ctrl: a reference model feeds a scoreboard every cycle, a vector table pins
// single-cycle admission rules, and scripted sequences walk the capacity schedule, hour wrap and reset.
module tb_parking_zone_ctrl;

  localparam int CNT_W  = 10;
  localparam int T_HOUR = 1000;
`ifdef PARKING_SPILL_EN
  localparam bit SPILL = 1'b1;
`else
  localparam bit SPILL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic             entry_ack, entry_rej, exit_err, uni_is_vacated_space, is_vacated_space;
  logic [CNT_W-1:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
  logic [4:0]       hour;

  always #5 clk = ~clk;

  parking_zone_ctrl #(
    .CNT_W(CNT_W), .UNI_CAP(500), .GEN_CAP_DAY(200), .GEN_STEP(50), .GEN_CAP_NIGHT(500),
    .RAMP_HOUR(13), .FULL_HOUR(16), .START_HOUR(8), .TICKS_PER_HOUR(T_HOUR)
  ) dut (
    .clk(clk), .rst(rst),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_ack(entry_ack), .entry_rej(entry_rej), .exit_err(exit_err),
    .uni_parked_car(uni_parked_car), .parked_car(parked_car),
    .uni_vacated_space(uni_vacated_space), .vacated_space(vacated_space),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .hour(hour)
  );

  typedef struct packed {
    logic             ack, rej, err;
    logic [CNT_W-1:0] uni, gen, usp, gsp;
    logic             uf, gf;
    logic [4:0]       hr;
  } obs_t;

  typedef struct {
    logic ce, cu, xe, xu;
    logic ack, rej, err;
    int   uni, gen, usp, gsp;
  } vec_t;

  obs_t sb_q[$];
  int   n_chk = 0, n_fail = 0, n_ack = 0, n_rej = 0;
  int   m_uni, m_gen, m_spill, m_hour, m_presc;

  function automatic int cap_of(input int h);
    if (h < 13) return 200;
    if (h < 16) return (200 + (h - 12) * 50 > 500) ? 500 : 200 + (h - 12) * 50;
    return 500;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("ack=%0b rej=%0b err=%0b uni=%0d gen=%0d usp=%0d gsp=%0d uf=%0b gf=%0b hr=%0d",
                     o.ack, o.rej, o.err, o.uni, o.gen, o.usp, o.gsp, o.uf, o.gf, o.hr);
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.ack = entry_ack; s.rej = entry_rej; s.err = exit_err;
    s.uni = uni_parked_car; s.gen = parked_car; s.usp = uni_vacated_space; s.gsp = vacated_space;
    s.uf = uni_is_vacated_space; s.gf = is_vacated_space; s.hr = hour;
    return s;
  endfunction

  task automatic model_step(input logic ce, cu, xe, xu, r, output obs_t e);
    bit ext_ok, ok, to_spill;
    int usp, gcap;
    e = '0;
    if (r) begin
      m_uni = 0; m_gen = 0; m_spill = 0; m_hour = 8; m_presc = 0;
    end else begin
      usp      = 500 - m_uni - m_spill;
      ext_ok   = xe && (xu ? (m_uni > 0) : (m_gen > 0 || m_spill > 0));
      ok       = 1'b0;
      to_spill = 1'b0;
      if (ce) begin
        if (cu) ok = (usp > 0) || (xe && xu && ext_ok);
        else begin
          ok = (m_gen < cap_of(m_hour)) || (xe && !xu && ext_ok);
          if (!ok && SPILL && usp > 0) begin ok = 1'b1; to_spill = 1'b1; end
        end
      end
      e.ack = ce && ok;
      e.rej = ce && !ok;
      e.err = xe && !ext_ok;
      if (!(ce && ok && xe && ext_ok && (cu == xu))) begin
        if (xe && ext_ok) begin
          if (xu) m_uni--;
          else if (m_spill > 0) m_spill--;
          else m_gen--;
        end
        if (ce && ok) begin
          if (cu) m_uni++;
          else if (to_spill) m_spill++;
          else m_gen++;
        end
      end
      if (m_presc == T_HOUR - 1) begin m_presc = 0; m_hour = (m_hour + 1) % 24; end
      else m_presc++;
    end
    gcap  = cap_of(m_hour);
    e.uni = CNT_W'(m_uni);
    e.gen = CNT_W'(m_gen);
    e.usp = CNT_W'(500 - m_uni - m_spill);
    e.gsp = CNT_W'((gcap > m_gen) ? gcap - m_gen : 0);
    e.uf  = (500 - m_uni - m_spill) != 0;
    e.gf  = gcap > m_gen;
    e.hr  = 5'(m_hour);
  endtask

  task automatic step(input logic ce, cu, xe, xu, r);
    obs_t e, g;
    car_entered = ce; is_uni_car_entered = cu; car_exited = xe; is_uni_car_exited = xu; rst = r;
    model_step(ce, cu, xe, xu, r, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sample();
    e = sb_q.pop_front();
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL scoreboard t=%0t got {%s} want {%s}", $time, fmt(g), fmt(e));
    end
    if (g.ack === 1'b1) n_ack++;
    if (g.rej === 1'b1) n_rej++;
    car_entered = 1'b0; is_uni_car_entered = 1'b0; car_exited = 1'b0; is_uni_car_exited = 1'b0; rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic idle_to_hour(input int h);
    int guard = 0;
    while (m_hour != h && guard < 30000) begin step(0, 0, 0, 0, 0); guard++; end
    chk($sformatf("hour_reached_%0d", h), 32'(hour), h);
  endtask

  task automatic idle_to_tick(input int h);
    int guard = 0;
    while (!(m_hour == h - 1 && m_presc == T_HOUR - 1) && guard < 30000) begin
      step(0, 0, 0, 0, 0);
      guard++;
    end
    chk($sformatf("pre_tick_hour_%0d", h), 32'(hour), h - 1);
  endtask

  initial begin
    vec_t vecs[9];
    int   a0;
    int   n_exits;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 499, 200};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 499, 199};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 499, 200};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 499, 200};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 500, 199};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 499, 199};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 499, 199};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 499, 199};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 500, 199};

    car_entered = 1'b0; is_uni_car_entered = 1'b0; car_exited = 1'b0; is_uni_car_exited = 1'b0; rst = 1'b1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_hour", 32'(hour), 8);
    chk("reset_uni_space", 32'(uni_vacated_space), 500);
    chk("reset_gen_space", 32'(vacated_space), 200);
    chk("reset_flags_pulses", {26'd0, uni_is_vacated_space, is_vacated_space, entry_ack, entry_rej, exit_err, 1'b0}, 32'b110000);

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].ce, vecs[i].cu, vecs[i].xe, vecs[i].xu, 1'b0);
      n_chk++;
      if ({entry_ack, entry_rej, exit_err} !== {vecs[i].ack, vecs[i].rej, vecs[i].err} ||
          uni_parked_car !== CNT_W'(vecs[i].uni) || parked_car !== CNT_W'(vecs[i].gen) ||
          uni_vacated_space !== CNT_W'(vecs[i].usp) || vacated_space !== CNT_W'(vecs[i].gsp)) begin
        n_fail++;
        $display("FAIL vec[%0d]: got ack=%0b rej=%0b err=%0b uni=%0d gen=%0d usp=%0d gsp=%0d want %0b %0b %0b %0d %0d %0d %0d",
                 i, entry_ack, entry_rej, exit_err, uni_parked_car, parked_car, uni_vacated_space, vacated_space,
                 vecs[i].ack, vecs[i].rej, vecs[i].err, vecs[i].uni, vecs[i].gen, vecs[i].usp, vecs[i].gsp);
      end
    end

    // Fill general pool to 200, then swap at hour 9.
    repeat (199) step(1, 0, 0, 0, 0);
    chk("fill_parked", 32'(parked_car), 200);
    chk("fill_vacated", 32'(vacated_space), 0);
    chk("fill_flag", 32'(is_vacated_space), 0);
    idle_to_hour(9);
    step(1, 0, 1, 0, 0);
    chk("swap_ack", 32'(entry_ack), 1);
    chk("swap_parked", 32'(parked_car), 200);

    idle_to_hour(10);
    step(1, 0, 0, 0, 0);
    chk("full_parked", 32'(parked_car), 200);
`ifdef PARKING_SPILL_EN
    chk("full_spill_ack", 32'(entry_ack), 1);
    chk("full_spill_uni_space", 32'(uni_vacated_space), 499);
`else
    chk("full_rej", 32'(entry_rej), 1);
`endif

    // Entry on the terminal tick of hour 12 is judged against the hour-12 capacity.
    idle_to_tick(13);
    step(1, 0, 0, 0, 0);
    chk("tick_hour", 32'(hour), 13);
    chk("tick_vacated", 32'(vacated_space), 50);
    chk("tick_decision", {30'd0, entry_ack, entry_rej}, SPILL ? 32'b10 : 32'b01);

    idle_to_hour(16);
    chk("h16_vacated", 32'(vacated_space), 300);
    a0 = n_ack;
    repeat (300) step(1, 0, 0, 0, 0);
    chk("h16_acks", n_ack - a0, 300);
    step(1, 0, 0, 0, 0);
    chk("h16_301st", {30'd0, entry_ack, entry_rej}, SPILL ? 32'b10 : 32'b01);
    chk("h16_parked", 32'(parked_car), 500);

    idle_to_hour(0);
    chk("wrap_vacated", 32'(vacated_space), 0);
    chk("wrap_flag", 32'(is_vacated_space), 0);
`ifndef PARKING_SPILL_EN
    step(1, 0, 0, 0, 0);
    chk("wrap_rej", 32'(entry_rej), 1);
    chk("wrap_parked", 32'(parked_car), 500);
`endif
    n_exits = SPILL ? 303 : 300;
    repeat (n_exits) step(0, 0, 1, 0, 0);
    chk("drain_parked", 32'(parked_car), 200);
`ifndef PARKING_SPILL_EN
    step(1, 0, 0, 0, 0);
    chk("at_cap_rej", 32'(entry_rej), 1);
`endif
    step(0, 0, 1, 0, 0);
    chk("below_cap_parked", 32'(parked_car), 199);
    step(1, 0, 0, 0, 0);
    chk("below_cap_ack", 32'(entry_ack), 1);
    chk("below_cap_refill", 32'(parked_car), 200);

    // Reset in the middle of a uni burst drops the in-flight entry.
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    chk("rst_ack", 32'(entry_ack), 0);
    chk("rst_uni", 32'(uni_parked_car), 0);
    chk("rst_gen", 32'(parked_car), 0);
    chk("rst_hour", 32'(hour), 8);
    chk("rst_spaces", {uni_vacated_space, vacated_space}, {CNT_W'(500), CNT_W'(200)});
    step(1, 1, 0, 0, 0);
    chk("post_rst_ack", 32'(entry_ack), 1);
    chk("post_rst_uni", 32'(uni_parked_car), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
